// File: rtl/if_stage.sv
// Instruction fetch stage: PC generation, single-outstanding fetch over req/ack,
// {pc, inst} buffer FIFO. Define IF_BYPASS_EN to forward an ack straight to the outputs when the buffer is empty.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | after reset, no request; fetch starts next cycle
// S_REQ   | request to fetch_pc outstanding
// S_FULL  | buffer full, request held off until a pop
// S_DRAIN | wrong-path request still outstanding; its data is dropped
module if_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_data_i,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  output logic        inst_valid_o,
  input  logic        inst_ready_i,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_FULL, S_DRAIN} state_t;

  state_t          state, state_nxt;
  logic [31:0]     fetch_pc;
  logic [31:0]     drain_pc;
  logic [31:0]     fifo_pc   [FIFO_DEPTH];
  logic [31:0]     fifo_inst [FIFO_DEPTH];
  logic [AW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   count, count_nxt;
  logic            ack_acc, bypass_hit, bypass_take;
  logic            pop, push, fifo_pop;
  logic [31:0]     branch_pc;
  logic            unused_target_bits;

  assign branch_pc          = {branch_target_i[31:2], 2'b00};
  assign unused_target_bits = ^branch_target_i[1:0];

  always_comb begin
    ack_acc = mem_ack_i && (state == S_REQ) && !branch_flag_i;
`ifdef IF_BYPASS_EN
    bypass_hit = ack_acc && (count == '0);
`else
    bypass_hit = 1'b0;
`endif
    bypass_take = bypass_hit && inst_ready_i;
    pop         = inst_valid_o && inst_ready_i && !branch_flag_i;
    push        = ack_acc && !bypass_take;
    fifo_pop    = pop && (count != '0);
    count_nxt   = count + CW'(push) - CW'(fifo_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  state_nxt = S_REQ;
      S_REQ: begin
        if (branch_flag_i) begin
          state_nxt = mem_ack_i ? S_REQ : S_DRAIN;
        end else if (ack_acc && (count_nxt == CW'(FIFO_DEPTH))) begin
          state_nxt = S_FULL;
        end
      end
      S_FULL: begin
        if (branch_flag_i || pop) state_nxt = S_REQ;
      end
      S_DRAIN: begin
        if (mem_ack_i) state_nxt = S_REQ;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    mem_req_o  = (state == S_REQ) || (state == S_DRAIN);
    mem_addr_o = 32'h0;
    if (state == S_REQ)   mem_addr_o = fetch_pc;
    if (state == S_DRAIN) mem_addr_o = drain_pc;
    inst_valid_o = (count != '0) || bypass_hit;
    pc_o   = 32'h0;
    inst_o = 32'h0;
    if (count != '0) begin
      pc_o   = fifo_pc[rd_ptr];
      inst_o = fifo_inst[rd_ptr];
    end else if (bypass_hit) begin
      pc_o   = fetch_pc;
      inst_o = mem_data_i;
    end
  end

  // Branch wins over everything: flush the buffer and retarget, even mid-request.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      drain_pc <= 32'h0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else if (branch_flag_i) begin
      fetch_pc <= branch_pc;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      if (state == S_REQ) drain_pc <= fetch_pc;
    end else begin
      if (ack_acc)  fetch_pc <= fetch_pc + 32'd4;
      if (push)     wr_ptr   <= wr_ptr + AW'(1);
      if (fifo_pop) rd_ptr   <= rd_ptr + AW'(1);
      count <= count_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc[wr_ptr]   <= fetch_pc;
      fifo_inst[wr_ptr] <= mem_data_i;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: a memory model acks requests, accepted words are
// queued as expected {pc, inst} and compared as the stage hands them downstream.
module tb_if_stage;

  localparam logic [31:0] RPC   = 32'h0000_0100;
  localparam int          DEPTH = 2;

  logic        clk;
  logic        rst;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack_i;
  logic [31:0] mem_data_i;
  logic        branch_flag_i;
  logic [31:0] branch_target_i;
  logic        inst_valid_o;
  logic        inst_ready_i;
  logic [31:0] pc_o;
  logic [31:0] inst_o;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  ent_t        sbq[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_fetch;
  logic [31:0] drain_addr;
  bit          draining;

  if_stage #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
    .clk             (clk),
    .rst             (rst),
    .mem_req_o       (mem_req_o),
    .mem_addr_o      (mem_addr_o),
    .mem_ack_i       (mem_ack_i),
    .mem_data_i      (mem_data_i),
    .branch_flag_i   (branch_flag_i),
    .branch_target_i (branch_target_i),
    .inst_valid_o    (inst_valid_o),
    .inst_ready_i    (inst_ready_i),
    .pc_o            (pc_o),
    .inst_o          (inst_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One cycle: drive inputs after the falling edge, sample 1 time unit later.
  task automatic step(input bit ack_en, input bit ready, input bit br, input logic [31:0] tgt);
    bit   acc;
    bit   exp_valid;
    ent_t e;
    @(negedge clk);
    mem_ack_i       = ack_en && mem_req_o;
    mem_data_i      = mem_ack_i ? mem_word(mem_addr_o) : 32'h0;
    inst_ready_i    = ready;
    branch_flag_i   = br;
    branch_target_i = tgt;
    #1;
    if (draining) begin
      check("drain_req", 32'(mem_req_o), 32'd1);
      check("drain_addr", mem_addr_o, drain_addr);
    end else if (mem_req_o) begin
      check("fetch_addr", mem_addr_o, exp_fetch);
    end
    acc       = mem_ack_i && mem_req_o && !br && !draining;
    exp_valid = (sbq.size() != 0);
`ifdef IF_BYPASS_EN
    if (acc && sbq.size() == 0) exp_valid = 1'b1;
`endif
    check("valid", 32'(inst_valid_o), 32'(exp_valid));
    if (!inst_valid_o) begin
      check("pc_empty", pc_o, 32'h0);
      check("inst_empty", inst_o, 32'h0);
    end
    if (acc) sbq.push_back({exp_fetch, mem_word(exp_fetch)});
    if (inst_valid_o && ready && !br) begin
      check("sb_nonempty", 32'(sbq.size() != 0), 32'd1);
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        check("out_pc", pc_o, e.pc);
        check("out_inst", inst_o, e.inst);
      end
    end
    if (acc) exp_fetch = exp_fetch + 32'd4;
    if (mem_ack_i && mem_req_o) draining = 1'b0;
    if (br) begin
      sbq.delete();
      if (mem_req_o && !mem_ack_i) begin
        if (!draining) drain_addr = exp_fetch;
        draining = 1'b1;
      end
      exp_fetch = {tgt[31:2], 2'b00};
    end
  endtask

  // Leaves the bench in the first cycle after reset release (state IDLE).
  task automatic do_reset(input bit late_ack);
    @(negedge clk);
    rst           = 1'b1;
    mem_ack_i     = 1'b0;
    branch_flag_i = 1'b0;
    inst_ready_i  = 1'b0;
    @(negedge clk);
    #1;
    check("rst_req", 32'(mem_req_o), 32'd0);
    check("rst_addr", mem_addr_o, 32'h0);
    check("rst_valid", 32'(inst_valid_o), 32'd0);
    check("rst_pc", pc_o, 32'h0);
    check("rst_inst", inst_o, 32'h0);
    sbq.delete();
    draining  = 1'b0;
    exp_fetch = RPC;
    @(negedge clk);
    rst        = 1'b0;
    mem_ack_i  = late_ack;
    mem_data_i = 32'hBAD0_BAD0;
    #1;
    check("idle_req", 32'(mem_req_o), 32'd0);
    check("idle_addr", mem_addr_o, 32'h0);
    check("idle_valid", 32'(inst_valid_o), 32'd0);
  endtask

  task automatic drain();
    repeat (3) step(1'b0, 1'b1, 1'b0, 32'h0);
    check("sb_empty", 32'(sbq.size()), 32'd0);
  endtask

  initial begin
    rst             = 1'b1;
    mem_ack_i       = 1'b0;
    mem_data_i      = 32'h0;
    branch_flag_i   = 1'b0;
    branch_target_i = 32'h0;
    inst_ready_i    = 1'b0;
    draining        = 1'b0;
    exp_fetch       = RPC;
    drain_addr      = 32'h0;

    // streaming, ack every cycle
    do_reset(1'b0);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    check("first_req", 32'(mem_req_o), 32'd1);
    check("first_addr", mem_addr_o, RPC);
`ifdef IF_BYPASS_EN
    check("ack_to_valid", 32'(inst_valid_o), 32'd1);
`else
    check("ack_to_valid", 32'(inst_valid_o), 32'd0);
`endif
    repeat (8) step(1'b1, 1'b1, 1'b0, 32'h0);
    drain();

    // buffer fills with ready low, one pop resumes fetching
    do_reset(1'b0);
    repeat (6) step(1'b1, 1'b0, 1'b0, 32'h0);
    check("full_req", 32'(mem_req_o), 32'd0);
    check("full_count", 32'(sbq.size()), 32'(DEPTH));
    step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    check("resume_req", 32'(mem_req_o), 32'd1);
    check("resume_addr", mem_addr_o, RPC + 32'h8);
    drain();

    // branch while a request is pending, ack three cycles later
    do_reset(1'b0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b1, 32'h0000_2003);
    repeat (2) begin
      step(1'b0, 1'b0, 1'b0, 32'h0);
      check("br_valid_low", 32'(inst_valid_o), 32'd0);
      check("br_addr_hold", mem_addr_o, RPC + 32'h4);
    end
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    check("br_new_addr", mem_addr_o, 32'h0000_2000);
    repeat (4) step(1'b1, 1'b1, 1'b0, 32'h0);
    drain();

    // branch and ack in the same cycle with one entry buffered
    do_reset(1'b0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b1, 32'h0000_3000);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    check("brack_valid", 32'(inst_valid_o), 32'd0);
    check("brack_req", 32'(mem_req_o), 32'd1);
    check("brack_addr", mem_addr_o, 32'h0000_3000);
    repeat (4) step(1'b1, 1'b1, 1'b0, 32'h0);
    drain();

    // simultaneous push and pop, occupancy stays at one
    do_reset(1'b0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b1, 1'b0, 32'h0);
      check("pp_valid", 32'(inst_valid_o), 32'd1);
      check("pp_pc", pc_o, RPC + 32'(4 * i));
    end
    drain();

    // reset with a request outstanding, late ack lands in IDLE
    do_reset(1'b0);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    do_reset(1'b1);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    check("restart_addr", mem_addr_o, RPC);
    repeat (3) step(1'b1, 1'b1, 1'b0, 32'h0);
    drain();

    // fetch address wraps at the top of the address space
    do_reset(1'b0);
    step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFF9);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    repeat (2) step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    check("wrap_addr", mem_addr_o, 32'h0);
    repeat (3) step(1'b1, 1'b1, 1'b0, 32'h0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
